// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: word type, buffered entry
// layout and the default reset PC.
package fetch_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    localparam word_t DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response channel and the register
// stage. A flush empties it and overrides any same-cycle push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; reads of it are only meaningful when !empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads with
// credit-based flow control, buffers responses and handles jump redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int    FIFO_DEPTH      = 2,
    parameter int    MAX_OUTSTANDING = 2,
    parameter word_t RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic  clk,
    input  logic  rst_n,
    output logic  imem_req_valid,
    input  logic  imem_req_ready,
    output word_t imem_addr,
    input  logic  imem_rsp_valid,
    input  word_t imem_rsp_data,
    output logic  instr_valid,
    input  logic  instr_ready,
    output word_t instr,
    output word_t instr_pc,
    input  logic  redirect_valid,
    input  word_t redirect_addr
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    word_t          pc;
    word_t          rsp_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;
    logic           run;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;
    logic [31:0]    inflight;
    logic           credit;
    logic           req_fire;
    logic           rsp_keep;

    // Words already requested count against buffer space so a response can
    // never find the FIFO full.
    assign inflight = 32'(outstanding) + 32'(fifo_count);
    assign credit   = (inflight < 32'(FIFO_DEPTH)) &&
                      (32'(outstanding) < 32'(MAX_OUTSTANDING));

    assign imem_req_valid = run && credit && !redirect_valid && (drop_cnt == '0);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    assign push_entry.instr = imem_rsp_data;
    assign push_entry.pc    = rsp_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (instr_ready),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

    // Holds requests off until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc     <= redirect_addr;
            rsp_pc <= redirect_addr;
        end else begin
            if (req_fire) pc     <= pc + 16'd1;
            if (rsp_keep) rsp_pc <= rsp_pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Every request still in flight after a redirect is stale, whether or not
    // it was already marked for dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - OW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an architectural model of the
// expected instruction stream is checked against every register-stage pop.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [15:0] RPC = 16'hFFFE;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  imem_req_valid, imem_req_ready;
    word_t imem_addr;
    logic  imem_rsp_valid;
    word_t imem_rsp_data;
    logic  instr_valid, instr_ready;
    word_t instr, instr_pc;
    logic  redirect_valid;
    word_t redirect_addr;

    fetch_unit #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] memq [$];      // memory model: accepted, unanswered addresses
    logic [31:0] expq [$];      // expected {instr, pc} stream
    logic [15:0] ref_pc;        // next architectural PC to enqueue
    logic [15:0] exp_req_addr;  // next address the fetch unit must request

    int  rdy_pct, mrdy_pct, rsp_pct, redir_pm;
    bit  hold, force_redir;
    logic [15:0] force_addr;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic refill();
        while (expq.size() < 4) begin
            expq.push_back({ref_pc ^ 16'hA5A5, ref_pc});
            ref_pc = ref_pc + 16'd1;
        end
    endtask

    // Driver: inputs change just after the rising edge.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk); #1;
            instr_ready    = ($urandom_range(99) < rdy_pct);
            imem_req_ready = ($urandom_range(99) < mrdy_pct);
            redirect_valid = 1'b0;
            if (force_redir || ($urandom_range(999) < redir_pm)) begin
                redirect_valid = 1'b1;
                redirect_addr  = force_redir ? force_addr : 16'($urandom);
                force_redir    = 0;
                expq.delete();
                ref_pc = redirect_addr;
            end
            refill();
            imem_rsp_valid = 1'b0;
            if (!hold && memq.size() > 0 && $urandom_range(99) < rsp_pct) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memq.pop_front() ^ 16'hA5A5;
            end
        end
    endtask

    // Monitor: samples on the falling edge, fully decoupled from the driver.
    logic        prev_redir, prev_req_wait;
    logic [15:0] prev_addr;
    int          idle;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_redir    = 1'b0;
            prev_req_wait = 1'b0;
            idle          = 0;
            exp_req_addr  = RPC;
        end else begin
            if (prev_redir) check("instr_valid_after_redirect", 32'(instr_valid), 0);
            if (prev_req_wait && !redirect_valid) begin
                check("req_valid_hold", 32'(imem_req_valid), 1);
                check("req_addr_hold", 32'(imem_addr), 32'(prev_addr));
            end
            if (redirect_valid) begin
                check("no_req_in_redirect", 32'(imem_req_valid), 0);
                exp_req_addr = redirect_addr;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", 32'(imem_addr), 32'(exp_req_addr));
                exp_req_addr = exp_req_addr + 16'd1;
                memq.push_back(imem_addr);
                check("outstanding_le_2", 32'(memq.size() <= 2), 1);
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                idle = 0;
                if (expq.size() == 0) begin
                    check("unexpected_instr", 32'(instr_pc), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(e[15:0]));
                    check("instr", 32'(instr), 32'(e[31:16]));
                end
            end else begin
                idle++;
                if (idle == 200) check("progress_watchdog", 32'(idle), 0);
            end
            prev_redir    = redirect_valid;
            prev_req_wait = imem_req_valid && !imem_req_ready;
            prev_addr     = imem_addr;
        end
    end

    logic [15:0] held_pc;
    int k;

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        instr_ready = 0; redirect_valid = 0; redirect_addr = '0;
        hold = 0; force_redir = 0; force_addr = '0;
        ref_pc = RPC;
        rdy_pct = 100; mrdy_pct = 100; rsp_pct = 100; redir_pm = 0;

        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        rst_n = 1'b1;

        // Free run across the PC wrap
        step(20);

        // Register stage stalls: buffer fills, requests stop, head held
        rdy_pct = 0;
        step(10);
        @(negedge clk);
        check("full_req_valid", 32'(imem_req_valid), 0);
        check("full_outstanding", 32'(memq.size()), 0);
        check("full_instr_valid", 32'(instr_valid), 1);
        held_pc = instr_pc;
        step(3);
        @(negedge clk);
        check("full_head_stable", 32'(instr_pc), 32'(held_pc));
        rdy_pct = 100;
        step(10);

        // Redirect with two requests in flight
        hold = 1;
        k = 0;
        while (memq.size() < 2 && k < 50) begin step(1); k++; end
        check("two_outstanding", 32'(memq.size()), 2);
        force_redir = 1; force_addr = 16'h0040;
        step(1);
        hold = 0;
        step(15);

        // Redirect during steady streaming (response + pop coincide)
        step(5);
        force_redir = 1; force_addr = 16'h1234;
        step(10);

        // Randomized traffic with sporadic redirects
        rdy_pct = 70; mrdy_pct = 70; rsp_pct = 60; redir_pm = 30;
        step(3000);

        // Reset in the middle of a stream with a full buffer
        rdy_pct = 0; mrdy_pct = 100; rsp_pct = 100; redir_pm = 0;
        step(10);
        @(negedge clk);
        check("pre_reset_instr_valid", 32'(instr_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_instr_valid", 32'(instr_valid), 0);
        check("mid_reset_req_valid", 32'(imem_req_valid), 0);
        memq.delete();
        expq.delete();
        ref_pc = RPC;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        rdy_pct = 100;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(20);
        check("restart_delivered", 32'(idle < 5), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the register/execute stage.
- Owns the program counter and issues in-order word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents them to the register stage through a valid/ready handshake.
- Accepts jump redirects from execute, which flush the buffer and discard in-flight stale responses.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests (>=1).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  16  word address of request (current PC).
- imem_rsp_valid  in  1  response data valid; responses in request order, always accepted.
- imem_rsp_data  in  16  instruction word.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  register stage consumes instr.
- instr  out  16  instruction to register stage.
- instr_pc  out  16  address the instruction was fetched from.
- redirect_valid  in  1  taken jump; pulse, one cycle.
- redirect_addr  in  16  jump target (execute's target register value).

Behaviour:
- Reset (async assert, sync-released use):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Credit: credit = (outstanding + fifo_count) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
- Request:
  - imem_req_valid = credit && !redirect_valid && (drop_cnt==0); imem_addr = pc.
  - imem_req_valid never depends on imem_req_ready.
  - Once asserted, valid and addr stay stable until the handshake, unless a redirect arrives.
  - Handshake: pc <= pc+1, wrapping 16'hFFFF -> 16'h0000; outstanding++.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: the word is discarded and drop_cnt--.
  - Otherwise: push {data, pc_of_request} into the FIFO. The PC is tracked by a separate response-PC counter advanced per accepted response.
  - No overflow is possible, by credit.
- Output:
  - instr_valid = FIFO non-empty; instr/instr_pc = FIFO head, combinational from storage.
  - instr_valid && instr_ready pops the head.
  - Zero-latency pass-through is not required; min latency from rsp to instr_valid is 1 cycle.
- Redirect (redirect_valid=1):
  - FIFO flushed, including any same-cycle pop or push.
  - pc <= redirect_addr; rsp-PC counter <= redirect_addr.
  - drop_cnt <= outstanding minus (1 if a response arrives this cycle and drop_cnt==0, else counted normally).
  - instr_valid=0 on the following cycle.
  - No request is issued in the redirect cycle.
  - Redirect wins over every simultaneous event.
- Consecutive redirects: the last one wins; drop_cnt accumulates correctly.
- Empty FIFO with instr_ready=1: no effect.
- Full FIFO: no requests issued; instr held stable until consumed.
- Memory stall (imem_req_ready=0 indefinitely): pc and imem_addr held.
- Reset mid-operation: all state cleared immediately. In-flight memory responses arriving after reset release are the environment's responsibility (memory is reset by the same rst_n).

Decomposition:
- Package fetch_pkg:
  - WORD_W=16.
  - Typedef word_t (logic [15:0]).
  - Typedef fetch_entry_t (struct: word_t instr, word_t pc).
  - Default RESET_PC constant.
- Sub-module fetch_fifo (parameterised depth, fetch_entry_t payload):
  - Ports: push, pop, flush, head, empty, count.
  - flush has priority over push/pop.
- Top-level holds PC, response-PC, outstanding and drop counters.

Test Plan:
- Reset, imem_req_ready=1, memory returns addr^16'hA5A5 one cycle after request, instr_ready=1 -> instr_pc sequence 0,1,2,3...; instr=16'hA5A5,16'hA5A4,...; never more than 2 outstanding.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, imem_req_valid=0; release -> words delivered in order, no loss or duplicate.
- Redirect to 16'h0040 while 2 requests outstanding -> both responses dropped; next instr_valid shows instr_pc=16'h0040; imem_addr=16'h0040 on first request after redirect.
- Redirect in the same cycle as a response and an instr pop -> FIFO empty next cycle, drop_cnt=outstanding-1, no stale instruction emitted.
- RESET_PC=16'hFFFE, free-running -> instr_pc 16'hFFFE,16'hFFFF,16'h0000,16'h0001.
- rst_n asserted mid-stream with a full FIFO -> instr_valid=0 and imem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
